// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory-bus arbiter: state encoding,
// master indices, default bus widths and the round-robin grant rule.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // A lone requester wins; on a tie the master that did not win last time wins.
    function automatic logic pick_master(input logic ifu_req, input logic lsu_req,
                                         input logic last);
        if (ifu_req && lsu_req) begin
            return ~last;
        end else if (lsu_req) begin
            return M_LSU;
        end
        return M_IFU;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter in front of a single
// memory slave. One transaction in flight; every transaction passes through
// IDLE, so a grant decision is made once per transaction.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    output logic                m0_resp_valid,
    input  logic                m0_resp_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic                m1_wen,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_resp_valid,
    input  logic                m1_resp_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic                s_wen,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_err,
    output logic                busy
);

    state_t state, state_next;
    logic   grant, grant_next;
    logic   last_grant, last_grant_next;
    logic   req_fire;
    logic   resp_fire;

    // State and grant registers; reset parks on IFU so the LSU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= M_IFU;
            last_grant <= M_IFU;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

    // Next state and the request/response mux toward the granted master.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        req_fire        = 1'b0;
        resp_fire       = 1'b0;
        m0_req_ready    = 1'b0;
        m0_resp_valid   = 1'b0;
        m0_rdata        = '0;
        m0_err          = 1'b0;
        m1_req_ready    = 1'b0;
        m1_resp_valid   = 1'b0;
        m1_rdata        = '0;
        m1_err          = 1'b0;
        s_req_valid     = 1'b0;
        s_wen           = 1'b0;
        s_addr          = '0;
        s_wdata         = '0;
        s_wmask         = '0;
        s_resp_ready    = 1'b0;

        unique case (state)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    grant_next = pick_master(m0_req_valid, m1_req_valid, last_grant);
                    state_next = REQ;
                end
            end
            REQ: begin
                if (grant == M_LSU) begin
                    s_req_valid  = m1_req_valid;
                    s_wen        = m1_wen;
                    s_addr       = m1_addr;
                    s_wdata      = m1_wdata;
                    s_wmask      = m1_wmask;
                    m1_req_ready = s_req_ready;
                    req_fire     = m1_req_valid && s_req_ready;
                end else begin
                    // IFU never writes: write fields stay at their zero defaults.
                    s_req_valid  = m0_req_valid;
                    s_addr       = m0_addr;
                    m0_req_ready = s_req_ready;
                    req_fire     = m0_req_valid && s_req_ready;
                end
                if (req_fire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (grant == M_LSU) begin
                    m1_resp_valid = s_resp_valid;
                    m1_rdata      = s_rdata;
                    m1_err        = s_err;
                    s_resp_ready  = m1_resp_ready;
                    resp_fire     = s_resp_valid && m1_resp_ready;
                end else begin
                    m0_resp_valid = s_resp_valid;
                    m0_rdata      = s_rdata;
                    m0_err        = s_err;
                    s_resp_ready  = m0_resp_ready;
                    resp_fire     = s_resp_valid && m0_resp_ready;
                end
                if (resp_fire) begin
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
